conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/viterbi_pkg.sv | 20 ++
 rtl/conv_enc_core.sv | 21 ++
 rtl/conv_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code: encoder, BMU, ACS and traceback.
package viterbi_pkg;

    localparam int CONV_K = 3;
    localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

    // Encoded symbol {g0 bit, g1 bit}, same layout the BMU consumes
    typedef logic [1:0] sym_t;

    typedef enum logic {
        DATA  = 1'b0,
        FLUSH = 1'b1
    } enc_state_t;

    function automatic logic parity3(input logic [CONV_K-1:0] taps);
        return ^taps;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational K=3 encoder kernel: symbol and next shift-register value from {u, sr}.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = CONV_G0,
    parameter logic [2:0] G1 = CONV_G1
) (
    input  logic       u,
    input  logic [1:0] sr,
    output logic [1:0] sym,
    output logic [1:0] sr_next
);

    logic [CONV_K-1:0] win;

    // Tap window ordered {current, previous, older} to line up with the polynomial bits
    assign win     = {u, sr[0], sr[1]};
    assign sym     = {parity3(G0 & win), parity3(G1 & win)};
    assign sr_next = {sr[0], u};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder with valid/ready handshake and one output register.
// Zero-tail frame termination is built when CONV_ENC_TAIL_FLUSH_EN is defined.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = CONV_G0,
    parameter logic [2:0] G1 = CONV_G1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [1:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    input  logic       i_ready
);

    enc_state_t state;
    logic [1:0] sr;
    logic [1:0] data_p1;
    logic       vld_p1;
    logic       last_p1;
    logic       out_free;
    logic       accept;
    logic       u;
    logic [1:0] sym;
    logic [1:0] sr_next;
`ifdef CONV_ENC_TAIL_FLUSH_EN
    logic       flush_cnt;
`endif

    assign out_free = !vld_p1 || i_ready;
    assign o_ready  = (state == DATA) && out_free;
    assign accept   = i_valid && o_ready;
    assign u        = (state == FLUSH) ? 1'b0 : i_data;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .u       (u),
        .sr      (sr),
        .sym     (sym),
        .sr_next (sr_next)
    );

    // Stage p1: output register, loaded from the kernel whenever it is free
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= DATA;
            sr      <= 2'b00;
            data_p1 <= 2'b00;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
`ifdef CONV_ENC_TAIL_FLUSH_EN
            flush_cnt <= 1'b0;
`endif
        end else begin
            if (vld_p1 && i_ready) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
            if (accept) begin
                data_p1 <= sym;
                vld_p1  <= 1'b1;
`ifdef CONV_ENC_TAIL_FLUSH_EN
                sr      <= sr_next;
                last_p1 <= 1'b0;
                if (i_last) begin
                    state     <= FLUSH;
                    flush_cnt <= 1'b0;
                end
`else
                // Without a tail the frame ends here, so the next frame starts from zero state
                sr      <= i_last ? 2'b00 : sr_next;
                last_p1 <= i_last;
`endif
            end
`ifdef CONV_ENC_TAIL_FLUSH_EN
            else if (state == FLUSH && out_free) begin
                // Two zero tail bits return sr to 00 on their own
                data_p1 <= sym;
                vld_p1  <= 1'b1;
                sr      <= sr_next;
                last_p1 <= flush_cnt;
                if (flush_cnt) begin
                    state     <= DATA;
                    flush_cnt <= 1'b0;
                end else begin
                    flush_cnt <= 1'b1;
                end
            end
`endif
        end
    end

    assign o_data  = data_p1;
    assign o_valid = vld_p1;
    assign o_last  = last_p1;

endmodule
